// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the ST7735S LCD path.
//   lcd_state_e      : transmitter states IDLE / SHIFT / GAP
//   LCD_CMD, LCD_DAT : a0 levels (command / data)
//   ST7735S opcodes used by the init and pixel sequencers
package lcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } lcd_state_e;

   localparam logic LCD_CMD = 1'b0;
   localparam logic LCD_DAT = 1'b1;

   localparam logic [7:0] SLPOUT = 8'h11;
   localparam logic [7:0] CASET  = 8'h2A;
   localparam logic [7:0] RASET  = 8'h2B;
   localparam logic [7:0] RAMWR  = 8'h2C;
   localparam logic [7:0] DISPON = 8'h29;
   localparam logic [7:0] COLMOD = 8'h3A;
   localparam logic [7:0] MADCTL = 8'h36;

endpackage

// File: rtl/lcd_spi_tx_if.sv
// lcd_spi_tx_if: byte handshake between the LCD sequencer and lcd_spi_tx.
//   in_valid : byte offered            (master -> slave)
//   in_ready : byte can be accepted    (slave  -> master)
//   in_dc    : a0 level, 0 = command   (master -> slave)
//   in_data  : byte to send            (master -> slave)
//   in_last  : release cs after byte   (master -> slave)
interface lcd_spi_tx_if;

   logic       in_valid;
   logic       in_ready;
   logic       in_dc;
   logic [7:0] in_data;
   logic       in_last;

   modport master (
      output in_valid,
      output in_dc,
      output in_data,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_dc,
      input  in_data,
      input  in_last,
      output in_ready
   );

endinterface

// File: rtl/lcd_spi_tick.sv
// lcd_spi_tick: half-period tick generator for the SPI clock.
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   i_clr  : synchronous clear, restarts the count at 0
//   i_en   : count enable
//   o_tick : one-cycle pulse on the last of every DIV enabled cycles
module lcd_spi_tick #(
   parameter int unsigned DIV = 5
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   logic [7:0] r_cnt;
   logic       w_term;

   assign w_term = (r_cnt == 8'(DIV - 1));
   assign o_tick = i_en && w_term;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_term ? '0 : r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: byte-level 4-wire SPI transmitter (mode 0) for the ST7735S.
//   clock   : system clock, all logic on posedge
//   reset   : synchronous active-high reset
//   in_if   : byte handshake (valid/ready, dc, data, last)
//   busy    : byte or cs gap in progress
//   lcd_cs  : chip select, active low
//   lcd_a0  : panel D/C line
//   lcd_sck : registered SPI clock, idles low
//   lcd_sda : registered SPI data
// Build option: define LCD_SPI_TX_LSB_FIRST_EN to shift LSB first (default MSB first).
module lcd_spi_tx
   import lcd_pkg::*;
#(
   parameter int unsigned DIV = 5,
   parameter int unsigned GAP = 2
) (
   input  logic        clock,
   input  logic        reset,
   lcd_spi_tx_if.slave in_if,
   output logic        busy,
   output logic        lcd_cs,
   output logic        lcd_a0,
   output logic        lcd_sck,
   output logic        lcd_sda
);

`ifdef LCD_SPI_TX_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

   lcd_state_e r_state, w_state_nxt;
   logic       r_ready, w_ready_nxt;
   logic       r_cs, w_cs_nxt;
   logic       r_a0, w_a0_nxt;
   logic       r_sck, w_sck_nxt;
   logic       r_sda, w_sda_nxt;
   logic       r_last, w_last_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic [2:0] r_bit, w_bit_nxt;
   logic [7:0] r_gap_cnt, w_gap_cnt_nxt;

   logic       w_tick;
   logic       w_tick_en;
   logic       w_last_fall;
   logic       w_gap_done;
   logic       w_ready;
   logic       w_accept;
   logic       w_first_bit;
   logic       w_next_bit;
   logic [7:0] w_shift_adv;

   assign w_tick_en   = (r_state == lcd_pkg::SHIFT);
   assign w_last_fall = w_tick && r_sck && (r_bit == 3'd7);
   assign w_gap_done  = (r_gap_cnt == 8'(GAP - 1));

   // Ready is also raised combinationally in the cycle whose closing edge ends
   // the byte (no in_last) or the cs gap, so the next byte starts on that very
   // edge and the sck stream stays contiguous.
   assign w_ready  = r_ready
                   || ((r_state == lcd_pkg::SHIFT) && w_last_fall && !r_last)
                   || ((r_state == lcd_pkg::GAP) && w_gap_done);
   assign w_accept = w_ready && in_if.in_valid;

   assign w_first_bit = LSB_FIRST ? in_if.in_data[0] : in_if.in_data[7];
   assign w_next_bit  = LSB_FIRST ? r_shift[1] : r_shift[6];
   assign w_shift_adv = LSB_FIRST ? {1'b0, r_shift[7:1]} : {r_shift[6:0], 1'b0};

   lcd_spi_tick #(
      .DIV (DIV)
   ) u_tick (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_clr  (w_accept),
      .i_en   (w_tick_en),
      .o_tick (w_tick)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_cs_nxt      = r_cs;
      w_a0_nxt      = r_a0;
      w_sck_nxt     = r_sck;
      w_sda_nxt     = r_sda;
      w_last_nxt    = r_last;
      w_shift_nxt   = r_shift;
      w_bit_nxt     = r_bit;
      w_gap_cnt_nxt = r_gap_cnt;

      unique case (r_state)
         lcd_pkg::IDLE: begin
         end
         lcd_pkg::SHIFT: begin
            if (w_tick) begin
               w_sck_nxt = ~r_sck;
               // Data only moves on falling edges, so it is stable across the high phase.
               if (r_sck) begin
                  if (r_bit != 3'd7) begin
                     w_bit_nxt   = r_bit + 3'd1;
                     w_shift_nxt = w_shift_adv;
                     w_sda_nxt   = w_next_bit;
                  end else if (r_last) begin
                     w_cs_nxt      = 1'b1;
                     w_gap_cnt_nxt = '0;
                     w_state_nxt   = lcd_pkg::GAP;
                  end else begin
                     w_state_nxt = lcd_pkg::IDLE;
                  end
               end
            end
         end
         lcd_pkg::GAP: begin
            if (w_gap_done) begin
               w_state_nxt = lcd_pkg::IDLE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nxt = lcd_pkg::IDLE;
         end
      endcase

      // Accept overrides the end-of-byte / end-of-gap transition taken above.
      if (w_accept) begin
         w_shift_nxt = in_if.in_data;
         w_last_nxt  = in_if.in_last;
         w_a0_nxt    = in_if.in_dc;
         w_cs_nxt    = 1'b0;
         w_sda_nxt   = w_first_bit;
         w_sck_nxt   = 1'b0;
         w_bit_nxt   = '0;
         w_state_nxt = lcd_pkg::SHIFT;
      end

      w_ready_nxt = (w_state_nxt == lcd_pkg::IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= lcd_pkg::IDLE;
         r_ready   <= 1'b0;
         r_cs      <= 1'b1;
         r_a0      <= 1'b0;
         r_sck     <= 1'b0;
         r_sda     <= 1'b0;
         r_last    <= 1'b0;
         r_shift   <= '0;
         r_bit     <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ready   <= w_ready_nxt;
         r_cs      <= w_cs_nxt;
         r_a0      <= w_a0_nxt;
         r_sck     <= w_sck_nxt;
         r_sda     <= w_sda_nxt;
         r_last    <= w_last_nxt;
         r_shift   <= w_shift_nxt;
         r_bit     <= w_bit_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
      end
   end

   assign in_if.in_ready = w_ready;
   assign busy           = (r_state != lcd_pkg::IDLE);
   assign lcd_cs         = r_cs;
   assign lcd_a0         = r_a0;
   assign lcd_sck        = r_sck;
   assign lcd_sda        = r_sda;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb_lcd_spi_tx: self-checking bench for lcd_spi_tx (DIV=5, GAP=2).
// Observes the wire at sck rising edges and compares against a byte-level model.
module tb_lcd_spi_tx;

   localparam int unsigned DIV = 5;
   localparam int unsigned GAP = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic busy, lcd_cs, lcd_a0, lcd_sck, lcd_sda;

   lcd_spi_tx_if bus ();

   lcd_spi_tx #(
      .DIV (DIV),
      .GAP (GAP)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .in_if   (bus),
      .busy    (busy),
      .lcd_cs  (lcd_cs),
      .lcd_a0  (lcd_a0),
      .lcd_sck (lcd_sck),
      .lcd_sda (lcd_sda)
   );

   always #10 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   // Wire monitor: panel-eye view of the bus.
   logic rise_bits[$];
   int   rise_cyc[$];
   logic prev_sck = 1'b0;
   logic hi_sda   = 1'b0;
   int   sda_viol = 0;
   int   cs_viol  = 0;

   always @(negedge clock) begin
      if (!reset) begin
         if (lcd_sck && !prev_sck) begin
            rise_bits.push_back(lcd_sda);
            rise_cyc.push_back(cyc);
            hi_sda = lcd_sda;
            if (lcd_cs) cs_viol++;
         end else if (lcd_sck && prev_sck && (lcd_sda !== hi_sda)) begin
            sda_viol++;
         end
      end
      prev_sck = lcd_sck;
   end

   typedef struct {
      logic       dc;
      logic [7:0] data;
      logic       last;
      int         exp_ready_off;
      int         exp_cs_hi;
   } vec_t;

   // Byte in the order it appears on the wire, first bit in [7].
   function automatic logic [7:0] wire_order(input logic [7:0] d);
      logic [7:0] r;
`ifdef LCD_SPI_TX_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) r[7-i] = d[i];
`else
      r = d;
`endif
      return r;
   endfunction

   function automatic vec_t mk_vec(input logic dc, input logic [7:0] d, input logic last);
      vec_t v;
      v.dc            = dc;
      v.data          = d;
      v.last          = last;
      v.exp_ready_off = 16 * DIV + (last ? GAP : 0);
      v.exp_cs_hi     = last ? GAP : 0;
      return v;
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // Offer a byte and wait (bounded) for acceptance; returns accept-edge cycle.
   task automatic send(input logic dc, input logic [7:0] d, input logic last, input bit hold,
                       input bit churn, input bit clr, output int t0, output int cs_hi,
                       output logic [7:0] sent);
      bit got;
      got          = 1'b0;
      cs_hi        = 0;
      t0           = -1;
      bus.in_valid = 1'b1;
      bus.in_dc    = dc;
      bus.in_data  = d;
      bus.in_last  = last;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (bus.in_ready) begin
            got = 1'b1;
            break;
         end
         if (lcd_cs) cs_hi++;
         if (churn) bus.in_data = 8'($urandom);
      end
      sent = bus.in_data;
      check("accept", longint'(got), 1);
      if (got) begin
         @(posedge clock);
         #1;
         t0 = cyc;
         if (clr) begin
            rise_bits.delete();
            rise_cyc.delete();
         end
      end
      if (!hold) bus.in_valid = 1'b0;
   endtask

   // Follow a byte from its accept edge until in_ready returns.
   task automatic finish(input int t0, output int ready_off, output int cs_hi,
                         output int busy_lo, output logic a0_t0, output logic cs_t0);
      ready_off = -1;
      cs_hi     = 0;
      busy_lo   = 0;
      a0_t0     = 1'bx;
      cs_t0     = 1'bx;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (cyc == t0) begin
            a0_t0 = lcd_a0;
            cs_t0 = lcd_cs;
         end
         if (lcd_cs) cs_hi++;
         if (!busy) busy_lo++;
         if (bus.in_ready) begin
            ready_off = cyc + 1 - t0;
            break;
         end
      end
   endtask

   task automatic check_bits(input string tag, input int t0, input int nbytes,
                             input logic [15:0] exp);
      logic [15:0] got;
      bit          tim_ok;
      got    = '0;
      tim_ok = 1'b1;
      foreach (rise_bits[i]) got = {got[14:0], rise_bits[i]};
      foreach (rise_cyc[i]) begin
         if (rise_cyc[i] != t0 + int'(DIV) + 2 * int'(DIV) * i) tim_ok = 1'b0;
      end
      check({tag, "_rises"}, rise_bits.size(), 8 * nbytes);
      check({tag, "_bits"}, got, exp);
      check({tag, "_timing"}, longint'(tim_ok), 1);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int         t0, cs_hi, ready_off, busy_lo;
      logic [7:0] sent;
      logic       a0_t0, cs_t0;
      send(v.dc, v.data, v.last, 1'b0, 1'b0, 1'b1, t0, cs_hi, sent);
      if (t0 < 0) return;
      finish(t0, ready_off, cs_hi, busy_lo, a0_t0, cs_t0);
      check_bits(tag, t0, 1, {8'h00, wire_order(v.data)});
      check({tag, "_a0"}, a0_t0, v.dc);
      check({tag, "_cs_t0"}, cs_t0, 0);
      check({tag, "_ready_off"}, ready_off, v.exp_ready_off);
      check({tag, "_cs_gap"}, cs_hi, v.exp_cs_hi);
      check({tag, "_busy"}, busy_lo, 0);
   endtask

   vec_t tbl[5];

   initial begin
      int         t0a, t0b, cs_hi, ready_off, busy_lo, dummy;
      logic [7:0] sent;
      logic       a0_t0, cs_t0;

      bus.in_valid = 1'b0;
      bus.in_dc    = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;

      tbl[0] = mk_vec(1'b0, 8'h2C, 1'b1);
      tbl[1] = mk_vec(1'b1, 8'h01, 1'b1);
      tbl[2] = mk_vec(1'b1, 8'hFF, 1'b0);
      tbl[3] = mk_vec(1'b0, 8'h80, 1'b0);
      tbl[4] = mk_vec(1'b1, 8'h00, 1'b1);

      // Reset values, then in_ready one cycle after release.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_cs", lcd_cs, 1);
      check("rst_sck", lcd_sck, 0);
      check("rst_sda", lcd_sda, 0);
      check("rst_a0", lcd_a0, 0);
      check("rst_ready", bus.in_ready, 0);
      check("rst_busy", busy, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rel_ready_first", bus.in_ready, 0);
      @(negedge clock);
      check("rel_ready", bus.in_ready, 1);
      check("rel_cs", lcd_cs, 1);

      foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

      // Back-to-back data with valid held.
      send(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, t0a, dummy, sent);
      send(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, t0b, cs_hi, sent);
      check("b2b_spacing", t0b - t0a, 16 * DIV);
      check("b2b_cs_low", cs_hi, 0);
      finish(t0b, ready_off, cs_hi, busy_lo, a0_t0, cs_t0);
      check_bits("b2b", t0a, 2, {wire_order(8'hA5), wire_order(8'h5A)});
      check("b2b_a0", a0_t0, 1);
      check("b2b_ready_off", ready_off, 16 * DIV + GAP);

      // Backpressure: data churns while not ready; only the accept-cycle value goes out.
      send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, t0a, dummy, sent);
      send(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1, 1'b1, t0b, dummy, sent);
      check("bp_wait", t0b - t0a, 16 * DIV);
      finish(t0b, ready_off, cs_hi, busy_lo, a0_t0, cs_t0);
      check_bits("bp", t0b, 1, {8'h00, wire_order(sent)});

      // Reset mid-byte at T0+37.
      send(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, t0a, dummy, sent);
      repeat (36) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("mid_busy_before", busy, 1);
      @(negedge clock);
      check("mid_cs", lcd_cs, 1);
      check("mid_sck", lcd_sck, 0);
      check("mid_sda", lcd_sda, 0);
      check("mid_a0", lcd_a0, 0);
      check("mid_busy", busy, 0);
      check("mid_ready", bus.in_ready, 0);
      reset = 1'b0;
      run_vec("post_rst", mk_vec(1'b0, 8'h36, 1'b1));

      // Randomized bytes against the byte-level model.
      for (int i = 0; i < 10; i++) begin
         run_vec($sformatf("rnd%0d", i),
                 mk_vec(1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0))));
      end

      check("sda_stable_high", sda_viol, 0);
      check("cs_low_on_rise", cs_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
